int24_to_float_tx: RTL and testbench

Source-side feeder for the float IIR filter chain. It accepts signed 24-bit ADC samples on a single-cycle strobe and buffers them in a small FIFO. Each sample is converted exactly to IEEE-754 single precision using a bit-serial normaliser. The result is driven to the filter's float input through a valid/ready handshake (transmitter end of the filter's `X_DATA` interface).

---
 rtl/int24_to_float_tx.sv | 157 +++++++++++++++
 tb/tb_int24_to_float_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/int24_to_float_tx.sv
`default_nettype none
// ============================================================================
//  Module      : int24_to_float_tx
//  Description : Buffers signed 24-bit ADC samples in a FIFO. Converts each one
//                exactly to IEEE-754 single precision with a bit-serial
//                normaliser, then sends it over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module int24_to_float_tx #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_CLK,
   input  logic        i_RSTN,
   input  logic [23:0] i_ADC_DATA,
   input  logic        i_ADC_DATA_VALID,
   input  logic        i_OVF_CLR,
   output logic        o_OVERFLOW,
   output logic [31:0] o_X_DATA,
   output logic        o_X_DATA_VALID,
   input  logic        i_X_DATA_READY
);

   localparam int              c_aw   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              c_cw   = $clog2(FIFO_DEPTH + 1);
   localparam logic [c_cw-1:0] c_full = c_cw'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   logic [23:0]     r_mem [FIFO_DEPTH];
   logic [c_aw-1:0] r_wptr;
   logic [c_aw-1:0] r_rptr;
   logic [c_cw-1:0] r_count;
   logic            r_overflow;

   state_t          r_state,  w_state_nxt;
   logic            r_sign,   w_sign_nxt;
   logic [23:0]     r_mag,    w_mag_nxt;
   logic [7:0]      r_exp,    w_exp_nxt;
   logic [31:0]     r_xdata,  w_xdata_nxt;
   logic            r_valid,  w_valid_nxt;

   logic            w_full;
   logic            w_push;
   logic            w_pop;
   logic [23:0]     w_head;

   // Full is judged on the pre-edge count, so a simultaneous pop never frees room.
   assign w_full = (r_count == c_full);
   assign w_push = i_ADC_DATA_VALID && !w_full;
   assign w_head = r_mem[r_rptr];

   always_ff @(posedge i_CLK) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_ADC_DATA;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_aw'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_aw'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
         if (i_ADC_DATA_VALID && w_full) begin
            r_overflow <= 1'b1;
         end else if (i_OVF_CLR) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_CLK or negedge i_RSTN) begin
      if (!i_RSTN) begin
         r_state <= ST_IDLE;
         r_sign  <= 1'b0;
         r_mag   <= '0;
         r_exp   <= '0;
         r_xdata <= '0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sign  <= w_sign_nxt;
         r_mag   <= w_mag_nxt;
         r_exp   <= w_exp_nxt;
         r_xdata <= w_xdata_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sign_nxt  = r_sign;
      w_mag_nxt   = r_mag;
      w_exp_nxt   = r_exp;
      w_xdata_nxt = r_xdata;
      w_valid_nxt = r_valid;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_sign_nxt  = w_head[23];
               // 24-bit negate: -8388608 wraps to 24'h800000, the correct magnitude.
               w_mag_nxt   = w_head[23] ? (~w_head + 24'd1) : w_head;
               w_exp_nxt   = 8'd150;
               w_state_nxt = ST_NORM;
            end
         end
         ST_NORM: begin
            if (r_mag == '0) begin
               w_xdata_nxt = 32'h0000_0000;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end else if (r_mag[23]) begin
               w_xdata_nxt = {r_sign, r_exp, r_mag[22:0]};
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end else begin
               w_mag_nxt   = {r_mag[22:0], 1'b0};
               w_exp_nxt   = r_exp - 8'd1;
            end
         end
         ST_SEND: begin
            if (r_valid && i_X_DATA_READY) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign o_OVERFLOW     = r_overflow;
   assign o_X_DATA       = r_xdata;
   assign o_X_DATA_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_int24_to_float_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int24_to_float_tx
//  Description : Self-checking bench for int24_to_float_tx; expected floats come
//                from the simulator's own double-precision conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int24_to_float_tx;

   logic        i_CLK = 1'b0;
   logic        i_RSTN;
   logic [23:0] i_ADC_DATA;
   logic        i_ADC_DATA_VALID;
   logic        i_OVF_CLR;
   logic        o_OVERFLOW;
   logic [31:0] o_X_DATA;
   logic        o_X_DATA_VALID;
   logic        i_X_DATA_READY;

   int checks = 0;
   int errors = 0;

   always #5 i_CLK = ~i_CLK;

   int24_to_float_tx #(.FIFO_DEPTH(4)) dut (
      .i_CLK            (i_CLK),
      .i_RSTN           (i_RSTN),
      .i_ADC_DATA       (i_ADC_DATA),
      .i_ADC_DATA_VALID (i_ADC_DATA_VALID),
      .i_OVF_CLR        (i_OVF_CLR),
      .o_OVERFLOW       (o_OVERFLOW),
      .o_X_DATA         (o_X_DATA),
      .o_X_DATA_VALID   (o_X_DATA_VALID),
      .i_X_DATA_READY   (i_X_DATA_READY)
   );

   // Repack the exact double of x into single precision (exponent bias 1023 -> 127).
   function automatic logic [31:0] ref_float(input int x);
      logic [63:0] b;
      if (x == 0) return 32'h0000_0000;
      b = $realtobits(real'(x));
      return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
   endfunction

   function automatic int ref_k(input int x);
      logic [63:0] b;
      if (x == 0) return 0;
      b = $realtobits(real'(x));
      return 23 - (int'(b[62:52]) - 1023);
   endfunction

   function automatic int rand_sample();
      int mag;
      mag = int'($urandom_range(0, 8388607) >> $urandom_range(0, 22));
      return ($urandom_range(0, 1) == 1) ? -mag : mag;
   endfunction

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input int x);
      i_ADC_DATA       = 24'(x);
      i_ADC_DATA_VALID = 1'b1;
      tick();
      i_ADC_DATA_VALID = 1'b0;
   endtask

   // Idle DUT, ready high: check latency 2+k, the value, and valid dropping after transfer.
   task automatic conv_check(input int x);
      int n;
      push(x);
      n = 0;
      while (!o_X_DATA_VALID && n < 40) begin
         tick();
         n++;
      end
      check($sformatf("latency(%0d)", x), 32'(n), 32'(2 + ref_k(x)));
      check($sformatf("data(%0d)", x), o_X_DATA, ref_float(x));
      tick();
      check($sformatf("valid_drop(%0d)", x), 32'(o_X_DATA_VALID), 32'd0);
   endtask

   task automatic drain(input int budget, output int got[$]);
      got = {};
      i_X_DATA_READY = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (o_X_DATA_VALID) got.push_back(int'(o_X_DATA));
         tick();
      end
   endtask

   initial begin
      int vals[$];
      int exp_q[$];
      int got[$];
      int n;

      i_RSTN = 1'b0; i_ADC_DATA = '0; i_ADC_DATA_VALID = 1'b0;
      i_OVF_CLR = 1'b0; i_X_DATA_READY = 1'b1;
      repeat (3) tick();
      check("rst_data", o_X_DATA, 32'h0);
      check("rst_valid", 32'(o_X_DATA_VALID), 32'd0);
      check("rst_ovf", 32'(o_OVERFLOW), 32'd0);
      i_RSTN = 1'b1;
      tick();

      foreach (vals[i]) vals.delete(i);
      vals = '{1, -1, 0, 100, 8388607, -8388608};
      foreach (vals[i]) conv_check(vals[i]);

      // Back-pressure: 1 in flight + 4 buffered, the sixth push is dropped.
      i_X_DATA_READY = 1'b0;
      vals = '{10, 20, 30, 40, 50, 60};
      foreach (vals[i]) begin
         push(vals[i]);
         check($sformatf("ovf_push%0d", i + 1), 32'(o_OVERFLOW), (i == 5) ? 32'd1 : 32'd0);
         repeat (29) tick();
      end
      for (int c = 0; c < 10; c++) begin
         check("hold_valid", 32'(o_X_DATA_VALID), 32'd1);
         check("hold_data", o_X_DATA, ref_float(10));
         tick();
      end
      i_X_DATA_READY = 1'b1;
      tick();
      i_X_DATA_READY = 1'b0;
      check("one_xfer_valid_low", 32'(o_X_DATA_VALID), 32'd0);
      drain(200, got);
      check("bp_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         check($sformatf("bp_order%0d", i), 32'(got[i]), ref_float(vals[i + 1]));

      // Overflow flag: clear alone, then drop coinciding with clear.
      i_X_DATA_READY = 1'b0;
      i_OVF_CLR = 1'b1; tick(); i_OVF_CLR = 1'b0;
      check("ovf_clear", 32'(o_OVERFLOW), 32'd0);
      exp_q = {};
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(rand_sample());
         push(exp_q[i]);
      end
      check("ovf_full_no_drop", 32'(o_OVERFLOW), 32'd0);
      repeat (30) tick();
      i_OVF_CLR = 1'b1;
      push(rand_sample());
      i_OVF_CLR = 1'b0;
      check("ovf_drop_beats_clr", 32'(o_OVERFLOW), 32'd1);
      tick();
      check("ovf_sticky", 32'(o_OVERFLOW), 32'd1);
      i_OVF_CLR = 1'b1; tick(); i_OVF_CLR = 1'b0;
      check("ovf_clear2", 32'(o_OVERFLOW), 32'd0);
      drain(250, got);
      check("fill_count", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5 && i < got.size(); i++)
         check($sformatf("fill_order%0d", i), 32'(got[i]), ref_float(exp_q[i]));

      // Reset while holding a result in the send stage.
      i_X_DATA_READY = 1'b0;
      push(7);
      n = 0;
      while (!o_X_DATA_VALID && n < 40) begin tick(); n++; end
      check("pre_rst_data", o_X_DATA, ref_float(7));
      #2 i_RSTN = 1'b0;
      #1;
      check("rst_send_data", o_X_DATA, 32'h0);
      check("rst_send_valid", 32'(o_X_DATA_VALID), 32'd0);
      #2 i_RSTN = 1'b1;
      tick();

      // Reset mid-normalisation: the sample is discarded.
      i_X_DATA_READY = 1'b1;
      push(1);
      repeat (4) tick();
      #2 i_RSTN = 1'b0;
      #1;
      check("rst_norm_valid", 32'(o_X_DATA_VALID), 32'd0);
      #2 i_RSTN = 1'b1;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (o_X_DATA_VALID) n++;
      end
      check("rst_discard", 32'(n), 32'd0);
      conv_check(100);

      for (int i = 0; i < 24; i++) conv_check(rand_sample());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
